// File: rtl/spike_event_packetizer.sv
// Spike event packetizer: turns rising detector flags into timestamped event words
// and queues them in a first-word-fall-through FIFO drained over valid/ready.
module spike_event_packetizer #(
  parameter int TS_WIDTH   = 24,
  parameter int FIFO_DEPTH = 16,
  parameter int REFRACTORY = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_valid,
  input  logic                          spike_neo,
  input  logic                          spike_ado,
  input  logic                          spike_aso,
  input  logic                          spike_ed,
  output logic [TS_WIDTH+3:0]           event_data,
  output logic                          event_valid,
  input  logic                          event_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [15:0]                   drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = $clog2(REFRACTORY + 1);
  localparam int EW = TS_WIDTH + 4;

  logic [TS_WIDTH-1:0]  ts_r;
  logic [3:0]           prev_r;
  logic [3:0][RW-1:0]   refr_r;
  logic [3:0][RW-1:0]   refr_nxt_s;
  logic [3:0]           flags_s;
  logic [3:0]           qual_s;
  logic                 stage_valid_r;
  logic [EW-1:0]        stage_data_r;

  logic [EW-1:0]        mem_r [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_r;
  logic [AW:0]          rd_ptr_r;
  logic [LW-1:0]        level_r;
  logic [LW-1:0]        level_nxt_s;
  logic                 event_valid_r;
  logic                 overflow_r;
  logic [15:0]          drop_count_r;
  logic                 full_s;
  logic                 pop_s;
  logic                 wr_s;
  logic                 drop_s;

  // Per-channel rise detection and refractory countdown for the current sample
  always_comb begin
    flags_s    = {spike_ed, spike_aso, spike_ado, spike_neo};
    qual_s     = 4'b0000;
    refr_nxt_s = refr_r;
    for (int c = 0; c < 4; c++) begin
      qual_s[c] = flags_s[c] && !prev_r[c] && (refr_r[c] == '0);
      if (qual_s[c]) begin
        refr_nxt_s[c] = RW'(REFRACTORY);
      end else if (refr_r[c] != '0) begin
        refr_nxt_s[c] = refr_r[c] - RW'(1);
      end else begin
        refr_nxt_s[c] = refr_r[c];
      end
    end
  end

  // Timestamp, previous flags, refractory counters and the staging register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_r          <= '0;
      prev_r        <= 4'b0000;
      refr_r        <= '0;
      stage_valid_r <= 1'b0;
      stage_data_r  <= '0;
    end else if (sample_valid) begin
      ts_r          <= ts_r + TS_WIDTH'(1);
      prev_r        <= flags_s;
      refr_r        <= refr_nxt_s;
      stage_valid_r <= |qual_s;
      stage_data_r  <= {qual_s, ts_r};
    end else begin
      stage_valid_r <= 1'b0;
    end
  end

  // Full is detected from the pointer wrap bit so all FIFO_DEPTH slots are usable
  always_comb begin
    full_s = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_s  = event_valid_r && event_ready;
    wr_s   = stage_valid_r && (!full_s || pop_s);
    drop_s = stage_valid_r && full_s && !pop_s;
    case ({wr_s, pop_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // FIFO storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= stage_data_r;
    end
  end

  // FIFO pointers, level, output valid and drop accounting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      level_r       <= '0;
      event_valid_r <= 1'b0;
      overflow_r    <= 1'b0;
      drop_count_r  <= 16'h0000;
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
      level_r       <= level_nxt_s;
      event_valid_r <= (level_nxt_s != '0);
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_count_r != 16'hFFFF) begin
          drop_count_r <= drop_count_r + 16'd1;
        end
      end
    end
  end

  assign event_data  = mem_r[rd_ptr_r[AW-1:0]];
  assign event_valid = event_valid_r;
  assign fifo_level  = level_r;
  assign overflow    = overflow_r;
  assign drop_count  = drop_count_r;

endmodule

// File: tb/tb_spike_event_packetizer.sv
// Directed self-checking bench for spike_event_packetizer: a default-parameter
// instance plus a TS_WIDTH=4 instance for timestamp wrap.
module tb_spike_event_packetizer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sv  = 1'b0;
  logic        neo = 1'b0, ado = 1'b0, aso = 1'b0, ed = 1'b0;
  logic        rdy = 1'b0;
  logic [27:0] ev_data;
  logic        ev_valid;
  logic [4:0]  lvl;
  logic        ovf;
  logic [15:0] dc;
  logic [7:0]  w_data;
  logic        w_valid;
  logic [4:0]  w_lvl;
  logic        w_ovf;
  logic [15:0] w_dc;

  int          checks = 0;
  int          errors = 0;
  bit          bp_en  = 1'b0;
  logic [27:0] popped [$];
  logic        hold_r = 1'b0;
  logic [27:0] hold_data = 28'h0;

  spike_event_packetizer u_dut (
    .clk(clk), .rst(rst), .sample_valid(sv),
    .spike_neo(neo), .spike_ado(ado), .spike_aso(aso), .spike_ed(ed),
    .event_data(ev_data), .event_valid(ev_valid), .event_ready(rdy),
    .fifo_level(lvl), .overflow(ovf), .drop_count(dc)
  );

  spike_event_packetizer #(.TS_WIDTH(4)) u_wrap (
    .clk(clk), .rst(rst), .sample_valid(sv),
    .spike_neo(neo), .spike_ado(ado), .spike_aso(aso), .spike_ed(ed),
    .event_data(w_data), .event_valid(w_valid), .event_ready(rdy),
    .fifo_level(w_lvl), .overflow(w_ovf), .drop_count(w_dc)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive strobe/flags at negedge, return 1ns after posedge
  task automatic tick(input bit s, input logic [3:0] f);
    @(negedge clk);
    sv = s;
    {ed, aso, ado, neo} = f;
    if (bp_en) rdy = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    sv = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; sv = 1'b0; {ed, aso, ado, neo} = 4'b0000; rdy = 1'b0; bp_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    popped.delete();
  endtask

  function automatic logic [27:0] ew(input int i);
    return {4'(1 << (i % 4)), 24'(9 * i)};
  endfunction

  // Accepted-word log and hold-stability check on the main instance
  always @(posedge clk) begin
    if (ev_valid && rdy) popped.push_back(ev_data);
    if (hold_r && ev_valid) check_eq("hold", ev_data, hold_data);
    hold_r    = ev_valid && !rdy;
    hold_data = ev_data;
  end

  initial begin
    #12;
    check_eq("rst_valid", ev_valid, 1'b0);
    check_eq("rst_data",  ev_data,  28'h0);
    check_eq("rst_level", lvl,      5'd0);
    check_eq("rst_ovf",   ovf,      1'b0);
    check_eq("rst_drops", dc,       16'd0);

    // Single NEO pulse: ts=5, visible two edges after the strobe
    do_reset();
    rdy = 1'b1;
    for (int t = 0; t < 5; t++) tick(1'b1, 4'b0000);
    tick(1'b1, 4'b0001);
    check_eq("lat_edge_n", ev_valid, 1'b0);
    tick(1'b0, 4'b0001);
    check_eq("lat_valid", ev_valid, 1'b1);
    check_eq("lat_data",  ev_data,  28'h1000005);
    tick(1'b0, 4'b0001);
    check_eq("lat_drop_valid", ev_valid, 1'b0);
    check_eq("single_count", popped.size(), 32'd1);

    // Simultaneous ADO+ED, then refractory on ADO
    do_reset();
    rdy = 1'b1;
    for (int t = 0; t < 10; t++) tick(1'b1, 4'b0000);
    tick(1'b1, 4'b1010);
    for (int t = 11; t < 30; t++) tick(1'b1, 4'b0000);
    tick(1'b1, 4'b0010);
    for (int t = 31; t < 43; t++) tick(1'b1, 4'b0000);
    tick(1'b1, 4'b0010);
    repeat (4) tick(1'b0, 4'b0000);
    check_eq("refr_count", popped.size(), 32'd2);
    if (popped.size() == 2) begin
      check_eq("simul_word", popped[0], 28'hA00000A);
      check_eq("refr_word",  popped[1], 28'h200002B);
    end

    // Level-held ASO, and flag pulses without a strobe
    do_reset();
    rdy = 1'b1;
    for (int t = 0; t < 100; t++) tick(1'b1, 4'b0100);
    tick(1'b0, 4'b1111);
    tick(1'b0, 4'b0000);
    tick(1'b0, 4'b1111);
    tick(1'b0, 4'b0000);
    tick(1'b1, 4'b0001);
    repeat (4) tick(1'b0, 4'b0000);
    check_eq("level_count", popped.size(), 32'd2);
    if (popped.size() == 2) begin
      check_eq("level_word", popped[0], 28'h4000000);
      check_eq("nostrobe_ts", popped[1], 28'h1000064);
    end

    // Overflow: 20 events with no readout, then drain
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 4'(1 << (i % 4)));
      repeat (8) tick(1'b1, 4'b0000);
    end
    repeat (3) tick(1'b0, 4'b0000);
    check_eq("ovf_level", lvl, 5'd16);
    check_eq("ovf_flag",  ovf, 1'b1);
    check_eq("ovf_drops", dc,  16'd4);
    rdy = 1'b1;
    repeat (20) tick(1'b0, 4'b0000);
    check_eq("ovf_drain_count", popped.size(), 32'd16);
    for (int i = 0; i < 16 && i < popped.size(); i++) check_eq("ovf_order", popped[i], ew(i));
    check_eq("ovf_empty_valid", ev_valid, 1'b0);
    check_eq("ovf_empty_level", lvl, 5'd0);

    // Backpressure: 50 events under random ready
    do_reset();
    bp_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1'b1, 4'(1 << (i % 4)));
      repeat (8) tick(1'b1, 4'b0000);
    end
    bp_en = 1'b0;
    rdy = 1'b1;
    repeat (30) tick(1'b0, 4'b0000);
    check_eq("bp_count", popped.size(), 32'd50);
    for (int i = 0; i < 50 && i < popped.size(); i++) check_eq("bp_order", popped[i], ew(i));
    check_eq("bp_ovf", ovf, 1'b0);

    // Timestamp wrap on the 4-bit instance, then asynchronous reset with 3 words queued
    do_reset();
    for (int t = 0; t < 16; t++) tick(1'b1, 4'b0000);
    tick(1'b1, 4'b0001);
    tick(1'b1, 4'b0010);
    check_eq("wrap_valid", w_valid, 1'b1);
    check_eq("wrap_data",  w_data,  8'h10);
    tick(1'b1, 4'b0100);
    repeat (2) tick(1'b0, 4'b0000);
    check_eq("queued_level", lvl, 5'd3);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_valid", ev_valid, 1'b0);
    check_eq("arst_data",  ev_data,  28'h0);
    check_eq("arst_level", lvl,      5'd0);
    check_eq("arst_wrap_level", w_lvl, 5'd0);
    @(negedge clk);
    rst = 1'b1;
    rdy = 1'b1;
    popped.delete();
    tick(1'b1, 4'b0001);
    repeat (3) tick(1'b0, 4'b0000);
    check_eq("post_rst_count", popped.size(), 32'd1);
    if (popped.size() == 1) check_eq("post_rst_ts", popped[0], 28'h1000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
